param_countdown_timer: RTL

Loadable, pausable countdown timer in M:SS.cc format with centisecond resolution, stepping down to 0:00.00.
Successor to the fixed 5-digit conventional timer: the clock rate, tick rate and maximum minutes are parameters, and it adds preset load, start/pause control, clamping and expiry status.
Drives five BCD digits to the existing hex_decoder instances; out_pulse feeds the game/round controller.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/bcd_down_digit.sv | 40 ++++
 rtl/param_countdown_timer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the M:SS.cc countdown timer.
package timer_pkg;

    localparam int unsigned DigitW     = 4;
    localparam int unsigned ModDecimal = 10;
    localparam int unsigned ModSexa    = 6;

    localparam logic [DigitW-1:0] LimDigit   = 4'd9;
    localparam logic [DigitW-1:0] LimSecTens = 4'd5;

    typedef enum logic [1:0] {
        StIdle,
        StRunning,
        StPaused,
        StExpired
    } state_e;

    function automatic logic [DigitW-1:0] clamp_bcd(input logic [DigitW-1:0] v,
                                                    input logic [DigitW-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MODULUS-1 and raises borrow_out while doing so.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic [DigitW-1:0] load_val,
    input  logic              dec,
    output logic              borrow_out,
    output logic [DigitW-1:0] value
);

    localparam logic [DigitW-1:0] TopVal = DigitW'(MODULUS - 1);

    logic [DigitW-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (dec) begin
            value_d = (value_q == '0) ? TopVal : value_q - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign borrow_out = dec && (value_q == '0);

endmodule

// File: rtl/param_countdown_timer.sv
// Loadable, pausable M:SS.cc countdown timer with centisecond ticks.
// Optional TIMER_AUTO_RELOAD_EN: reload the stored preset on expiry and keep running.
module param_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned TICK_HZ     = 100,
    parameter int unsigned MAX_MINUTES = 9
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic [19:0] preset,
    output logic [3:0]  digit4,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic        running,
    output logic        expired,
    output logic        out_pulse
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DivW-1:0]   DivLast = DivW'(DIV - 1);
    localparam logic [DigitW-1:0] MaxMin  = DigitW'(MAX_MINUTES);

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic            pulse_q, pulse_d;

    logic [19:0] digits;
    logic [19:0] preset_clamped;
    logic [19:0] dig_val;
    logic [4:0]  dec;
    logic [4:0]  borrow;
    logic        dig_load;
    logic        tick;
    logic        expire;
    logic        unused_min_borrow;

    assign preset_clamped = {clamp_bcd(preset[19:16], MaxMin),
                             clamp_bcd(preset[15:12], LimSecTens),
                             clamp_bcd(preset[11:8],  LimDigit),
                             clamp_bcd(preset[7:4],   LimDigit),
                             clamp_bcd(preset[3:0],   LimDigit)};

    // A pause or load in the same cycle freezes the tick that would otherwise fire.
    assign tick   = (state_q == StRunning) && !load && !pause && (div_q == DivLast);
    assign expire = tick && (digits == 20'h00001);

`ifdef TIMER_AUTO_RELOAD_EN
    logic [19:0] preset_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            preset_q <= '0;
        end else if (load) begin
            preset_q <= preset_clamped;
        end
    end

    assign dig_load = load || expire;
    assign dig_val  = load ? preset_clamped : preset_q;
`else
    assign dig_load = load;
    assign dig_val  = preset_clamped;
`endif

    assign dec[0] = tick;
    assign dec[4:1] = borrow[3:0];
    assign unused_min_borrow = borrow[4];

    for (genvar i = 0; i < 5; i++) begin : g_digit
        bcd_down_digit #(
            .MODULUS((i == 3) ? ModSexa : ModDecimal)
        ) u_digit (
            .clock     (clock),
            .resetn    (resetn),
            .load      (dig_load),
            .load_val  (dig_val[4*i +: 4]),
            .dec       (dec[i]),
            .borrow_out(borrow[i]),
            .value     (digits[4*i +: 4])
        );
    end

    always_comb begin
        div_d = div_q;
        if (load) begin
            div_d = '0;
        end else if (state_q == StRunning && !pause) begin
            div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
        end else if (state_q == StIdle) begin
            div_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        pulse_d = expire;
        if (load) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (start && (digits != '0)) state_d = StRunning;
                StRunning: begin
                    if (pause) begin
                        state_d = StPaused;
                    end else if (expire) begin
`ifdef TIMER_AUTO_RELOAD_EN
                        state_d = StRunning;
`else
                        state_d = StExpired;
`endif
                    end
                end
                StPaused:  if (start) state_d = StRunning;
                StExpired: state_d = StExpired;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            div_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pulse_q <= pulse_d;
        end
    end

    assign {digit4, digit3, digit2, digit1, digit0} = digits;
    assign running   = (state_q == StRunning);
    assign expired   = (state_q == StExpired);
    assign out_pulse = pulse_q;

endmodule
